// File: rtl/keypoint_write_arbiter.sv
// Keypoint write arbiter: three per-octave FIFOs drained round-robin into
// consecutive keypoint BRAM addresses, each entry tagged with its octave.
module keypoint_write_arbiter #(
    parameter int unsigned DIMENSION        = 64,
    parameter int unsigned NUMBER_KEYPOINTS = 1000,
    parameter int unsigned FIFO_DEPTH       = 4,
    localparam int unsigned LW = $clog2(DIMENSION),
    localparam int unsigned AW = $clog2(NUMBER_KEYPOINTS)
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic            start,
    input  logic            o1_valid,
    input  logic [LW-1:0]   o1_x,
    input  logic [LW-1:0]   o1_y,
    output logic            o1_ready,
    input  logic            o1_done,
    input  logic            o2_valid,
    input  logic [LW-1:0]   o2_x,
    input  logic [LW-1:0]   o2_y,
    output logic            o2_ready,
    input  logic            o2_done,
    input  logic            o3_valid,
    input  logic [LW-1:0]   o3_x,
    input  logic [LW-1:0]   o3_y,
    output logic            o3_ready,
    input  logic            o3_done,
    output logic            key_wea,
    output logic [AW-1:0]   key_write_addr,
    output logic [2*LW+1:0] keypoint_out,
    output logic [AW:0]     key_count,
    output logic            overflow,
    output logic            keypoints_done
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = 2 * LW;
    localparam logic [AW:0] KeyCap = (AW + 1)'(NUMBER_KEYPOINTS);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [2:0]      valid_in, done_in, ready, push, empty, full;
    logic [2:0]      done_q, done_d;
    logic [EW-1:0]   data_in [3];
    logic [EW-1:0]   mem_q [3][FIFO_DEPTH];
    logic [PW:0]     wr_ptr_q [3];
    logic [PW:0]     wr_ptr_d [3];
    logic [PW:0]     rd_ptr_q [3];
    logic [PW:0]     rd_ptr_d [3];
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [AW:0]     key_count_q, key_count_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [EW+1:0]   kp_q, kp_d;
    logic            wea_q, wea_d;
    logic            overflow_q, overflow_d;
    logic            active;
    logic            gnt_any;
    logic [1:0]      gnt_idx;
    logic [EW-1:0]   pop_data;

    assign valid_in   = {o3_valid, o2_valid, o1_valid};
    assign done_in    = {o3_done, o2_done, o1_done};
    assign data_in[0] = {o1_y, o1_x};
    assign data_in[1] = {o2_y, o2_x};
    assign data_in[2] = {o3_y, o3_x};

    assign active   = (state_q == StRun) || (state_q == StDrain);
    assign o1_ready = ready[0];
    assign o2_ready = ready[1];
    assign o3_ready = ready[2];

    // FIFO status, handshakes and pointer updates.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][PW] != rd_ptr_q[i][PW]) &&
                       (wr_ptr_q[i][PW-1:0] == rd_ptr_q[i][PW-1:0]);
            // No push-through: a full FIFO refuses even while it pops.
            ready[i] = active && !full[i];
            push[i]  = valid_in[i] && ready[i];
            wr_ptr_d[i] = wr_ptr_q[i] + (PW + 1)'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + (PW + 1)'(gnt_any && (gnt_idx == 2'(i)));
        end
    end

    // Round-robin grant: first non-empty FIFO searching from the pointer.
    always_comb begin
        int c;
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            c = int'(rr_ptr_q) + k;
            if (c >= 3) c = c - 3;
            if (active && !gnt_any && !empty[c]) begin
                gnt_any = 1'b1;
                gnt_idx = 2'(c);
            end
        end
    end

    assign pop_data = mem_q[gnt_idx][rd_ptr_q[gnt_idx][PW-1:0]];

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i][PW-1:0]] <= data_in[i];
        end
    end

    // Session FSM, write-port registers, counters and sticky flags.
    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        rr_ptr_d    = rr_ptr_q;
        key_count_d = key_count_q;
        addr_d      = addr_q;
        kp_d        = kp_q;
        wea_d       = 1'b0;
        overflow_d  = overflow_q;

        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            if (key_count_q < KeyCap) begin
                wea_d       = 1'b1;
                kp_d        = {gnt_idx + 2'd1, pop_data};
                addr_d      = key_count_q[AW-1:0];
                key_count_d = key_count_q + (AW + 1)'(1);
            end else begin
                // BRAM full: drop the entry but keep popping so sources never stall.
                overflow_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StRun;
                    done_d      = 3'b000;
                    rr_ptr_d    = 2'd0;
                    key_count_d = '0;
                    addr_d      = '0;
                    overflow_d  = 1'b0;
                end
            end
            StRun: begin
                done_d = done_q | done_in;
                if (&done_q) state_d = StDrain;
            end
            StDrain: begin
                // A push this cycle would land in an empty FIFO after we leave.
                if ((&empty) && !(|push)) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            done_q      <= 3'b000;
            rr_ptr_q    <= 2'd0;
            key_count_q <= '0;
            addr_q      <= '0;
            kp_q        <= '0;
            wea_q       <= 1'b0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            rr_ptr_q    <= rr_ptr_d;
            key_count_q <= key_count_d;
            addr_q      <= addr_d;
            kp_q        <= kp_d;
            wea_q       <= wea_d;
            overflow_q  <= overflow_d;
            for (int i = 0; i < 3; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
        end
    end

    assign key_wea        = wea_q;
    assign key_write_addr = addr_q;
    assign keypoint_out   = kp_q;
    assign key_count      = key_count_q;
    assign overflow       = overflow_q;
    assign keypoints_done = (state_q == StDone);

endmodule
